// File: rtl/tx_frame_scheduler_if.sv
// tx_frame_scheduler_if
//   Groups the per-source request/payload handshakes and the transmitter-side
//   GMII outputs of the transmit frame scheduler.
//   master : the scheduler (drives grants, read strobes and the frame bus)
//   slave  : the sources / transmitter side (drives requests, lengths, data)
//   Signals:
//     req_a/req_b     level request from source A/B
//     len_a/len_b     payload byte count, sampled on the grant edge
//     data_a/data_b   current payload byte of each source
//     gnt_a/gnt_b     one-cycle grant pulse
//     rd_a/rd_b       byte strobe, data captured at the edge ending a high cycle
//     TX_EN/tx_octet  frame-valid and frame octet towards the PCS transmitter
//     busy            scheduler is not idle
interface tx_frame_scheduler_if #(
  parameter int LEN_W = 11
);
  logic             req_a;
  logic             req_b;
  logic [LEN_W-1:0] len_a;
  logic [LEN_W-1:0] len_b;
  logic [7:0]       data_a;
  logic [7:0]       data_b;
  logic             gnt_a;
  logic             gnt_b;
  logic             rd_a;
  logic             rd_b;
  logic             TX_EN;
  logic [7:0]       tx_octet;
  logic             busy;

  modport master (
    input  req_a, req_b, len_a, len_b, data_a, data_b,
    output gnt_a, gnt_b, rd_a, rd_b, TX_EN, tx_octet, busy
  );

  modport slave (
    output req_a, req_b, len_a, len_b, data_a, data_b,
    input  gnt_a, gnt_b, rd_a, rd_b, TX_EN, tx_octet, busy
  );
endinterface

// File: rtl/tx_frame_scheduler.sv
// tx_frame_scheduler
//   Round-robin scheduler between two frame sources in front of a 1000BASE-X
//   PCS transmitter. Emits 7 preamble octets, an SFD and the granted source's
//   payload, then holds TX_EN low for at least IPG_CYCLES cycles.
//   Ports:
//     GTX_CLK  transmit clock, rising edge
//     RESET    synchronous active-low reset
//     bus      tx_frame_scheduler_if.master (requests, payload, grants,
//              read strobes, TX_EN/tx_octet, busy)
//   All outputs are registered.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | arbitrate, wait for a request
//   PRE    | 7 preamble octets (0x55), timer counts 6..0
//   SFD    | start-of-frame delimiter (0xD5), first payload byte fetched
//   DATA   | len payload octets, remaining count counts down to 0
//   IPG    | TX_EN low, timer counts IPG_CYCLES-1..0; last cycle arbitrates
module tx_frame_scheduler #(
  parameter int IPG_CYCLES = 12,
  parameter int LEN_W      = 11
) (
  input  logic                  GTX_CLK,
  input  logic                  RESET,
  tx_frame_scheduler_if.master  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_SFD,
    S_DATA,
    S_IPG
  } state_t;

  localparam int IPG_W = $clog2(IPG_CYCLES);
  localparam int TMR_W = (IPG_W > 3) ? IPG_W : 3;

  state_t           state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             sel_b_q, sel_b_d;
  logic             prefer_a_q, prefer_a_d;
  logic             gnt_a_q, gnt_a_d;
  logic             gnt_b_q, gnt_b_d;
  logic             rd_a_q, rd_a_d;
  logic             rd_b_q, rd_b_d;
  logic             tx_en_q, tx_en_d;
  logic [7:0]       tx_octet_q, tx_octet_d;
  logic             busy_q, busy_d;

  logic             arb;
  logic             rd_sel;
  logic             win_a;
  logic             win_b;
  logic [7:0]       data_sel;

  // Tie goes to whichever source was not served last.
  assign win_a    = bus.req_a & (~bus.req_b | prefer_a_q);
  assign win_b    = bus.req_b & (~bus.req_a | ~prefer_a_q);
  assign data_sel = sel_b_q ? bus.data_b : bus.data_a;

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    rem_d      = rem_q;
    sel_b_d    = sel_b_q;
    prefer_a_d = prefer_a_q;
    gnt_a_d    = 1'b0;
    gnt_b_d    = 1'b0;
    rd_sel     = 1'b0;
    tx_en_d    = 1'b0;
    tx_octet_d = 8'h00;
    arb        = 1'b0;

    case (state_q)
      S_IDLE: arb = 1'b1;
      S_PRE: begin
        tx_en_d    = 1'b1;
        tx_octet_d = 8'h55;
        if (tmr_q == '0) begin
          state_d    = S_SFD;
          tx_octet_d = 8'hD5;
          rd_sel     = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      S_SFD: begin
        // rem_q holds the full length here; the byte fetched now is byte 1.
        state_d    = S_DATA;
        tx_en_d    = 1'b1;
        tx_octet_d = data_sel;
        rd_sel     = (rem_q != LEN_W'(1));
        rem_d      = rem_q - LEN_W'(1);
      end
      S_DATA: begin
        if (rem_q == '0) begin
          state_d = S_IPG;
          tmr_d   = TMR_W'(IPG_CYCLES - 1);
        end else begin
          tx_en_d    = 1'b1;
          tx_octet_d = data_sel;
          rd_sel     = (rem_q != LEN_W'(1));
          rem_d      = rem_q - LEN_W'(1);
        end
      end
      S_IPG: begin
        if (tmr_q == '0) begin
          state_d = S_IDLE;
          arb     = 1'b1;
        end else begin
          tmr_d = tmr_q - TMR_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (arb && (win_a || win_b)) begin
      state_d    = S_PRE;
      tmr_d      = TMR_W'(6);
      gnt_a_d    = win_a;
      gnt_b_d    = win_b;
      sel_b_d    = win_b;
      prefer_a_d = win_b;
      tx_en_d    = 1'b1;
      tx_octet_d = 8'h55;
      if (win_b) rem_d = (bus.len_b == '0) ? LEN_W'(1) : bus.len_b;
      else       rem_d = (bus.len_a == '0) ? LEN_W'(1) : bus.len_a;
    end

    rd_a_d = rd_sel & ~sel_b_q;
    rd_b_d = rd_sel & sel_b_q;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge GTX_CLK) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      rem_q      <= '0;
      sel_b_q    <= 1'b0;
      prefer_a_q <= 1'b1;
      gnt_a_q    <= 1'b0;
      gnt_b_q    <= 1'b0;
      rd_a_q     <= 1'b0;
      rd_b_q     <= 1'b0;
      tx_en_q    <= 1'b0;
      tx_octet_q <= 8'h00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      rem_q      <= rem_d;
      sel_b_q    <= sel_b_d;
      prefer_a_q <= prefer_a_d;
      gnt_a_q    <= gnt_a_d;
      gnt_b_q    <= gnt_b_d;
      rd_a_q     <= rd_a_d;
      rd_b_q     <= rd_b_d;
      tx_en_q    <= tx_en_d;
      tx_octet_q <= tx_octet_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.gnt_a    = gnt_a_q;
  assign bus.gnt_b    = gnt_b_q;
  assign bus.rd_a     = rd_a_q;
  assign bus.rd_b     = rd_b_q;
  assign bus.TX_EN    = tx_en_q;
  assign bus.tx_octet = tx_octet_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_tx_frame_scheduler.sv
module tb_tx_frame_scheduler;

  logic gtx_clk = 1'b0;
  logic rst_n   = 1'b0;

  always #4 gtx_clk = ~gtx_clk;

  tx_frame_scheduler_if #(.LEN_W(11)) bus ();
  tx_frame_scheduler_if #(.LEN_W(11)) bus4 ();

  tx_frame_scheduler #(.IPG_CYCLES(12), .LEN_W(11)) dut (
    .GTX_CLK (gtx_clk),
    .RESET   (rst_n),
    .bus     (bus)
  );

  tx_frame_scheduler #(.IPG_CYCLES(4), .LEN_W(11)) dut4 (
    .GTX_CLK (gtx_clk),
    .RESET   (rst_n),
    .bus     (bus4)
  );

  typedef struct packed {
    logic       en;
    logic [7:0] oct;
    logic       ga;
    logic       gb;
    logic       ra;
    logic       rb;
    logic       busy;
  } smp_t;

  smp_t log_q[$];
  bit   rec = 1'b0;

  int n_chk = 0;
  int n_err = 0;

  // source-model state
  int lim_a = 0, lim_b = 0, gnts_a = 0, gnts_b = 0;
  int idx_a = 0, idx_b = 0;
  bit rd_a_prev = 1'b0, rd_b_prev = 1'b0;

  int exp_src[4];  // 0 = A, 1 = B
  int exp_len[4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Sources: payload byte n of a frame is base+n; the byte advances after
  // every edge that ended an rd-high cycle. A request drops once the source
  // has collected its allotted number of grants.
  initial forever begin
    smp_t s;
    @(negedge gtx_clk);
    if (rec) begin
      s.en   = bus.TX_EN;
      s.oct  = bus.tx_octet;
      s.ga   = bus.gnt_a;
      s.gb   = bus.gnt_b;
      s.ra   = bus.rd_a;
      s.rb   = bus.rd_b;
      s.busy = bus.busy;
      log_q.push_back(s);
    end
    if (rd_a_prev) idx_a++;
    if (rd_b_prev) idx_b++;
    if (bus.gnt_a) begin
      idx_a = 0;
      gnts_a++;
      if (gnts_a >= lim_a) bus.req_a = 1'b0;
    end
    if (bus.gnt_b) begin
      idx_b = 0;
      gnts_b++;
      if (gnts_b >= lim_b) bus.req_b = 1'b0;
    end
    rd_a_prev   = bus.rd_a;
    rd_b_prev   = bus.rd_b;
    bus.data_a  = 8'hA1 + 8'(idx_a);
    bus.data_b  = 8'hB1 + 8'(idx_b);
  end

  task automatic analyze(input string tag, input int n_fr, input int first_start, input int gap);
    int pos, prev_end, s, e, le, k, nbad, gn, rdn, rdf, rdl, rdo, blow, extra;
    logic [7:0] eo;
    logic r_sel, r_oth;
    pos = 0;
    prev_end = 0;
    for (int f = 0; f < n_fr; f++) begin
      s = -1;
      for (int i = pos; i < log_q.size(); i++) begin
        if (log_q[i].en) begin
          s = i;
          break;
        end
      end
      check($sformatf("%s.f%0d.found", tag, f), 32'(s >= 0), 1);
      if (s < 0) return;
      e = s;
      while (e < log_q.size() && log_q[e].en) e++;
      le = (exp_len[f] == 0) ? 1 : exp_len[f];
      check($sformatf("%s.f%0d.en_len", tag, f), e - s, 8 + le);
      if (f == 0) begin
        check($sformatf("%s.f%0d.start", tag, f), s, first_start);
      end else begin
        check($sformatf("%s.f%0d.gap", tag, f), s - prev_end, gap);
        blow = 0;
        for (int i = prev_end; i < s; i++) if (!log_q[i].busy) blow++;
        check($sformatf("%s.f%0d.gap_busy_low", tag, f), blow, 0);
      end
      check($sformatf("%s.f%0d.gnt", tag, f), {log_q[s].ga, log_q[s].gb},
            (exp_src[f] != 0) ? 2'b01 : 2'b10);
      nbad = 0; gn = 0; rdn = 0; rdf = -1; rdl = -1; rdo = 0; blow = 0;
      for (int i = s; i < e; i++) begin
        k = i - s;
        if (k < 7)       eo = 8'h55;
        else if (k == 7) eo = 8'hD5;
        else             eo = ((exp_src[f] != 0) ? 8'hB1 : 8'hA1) + 8'(k - 8);
        if (log_q[i].oct !== eo) nbad++;
        if (log_q[i].ga || log_q[i].gb) gn++;
        if (!log_q[i].busy) blow++;
        r_sel = (exp_src[f] != 0) ? log_q[i].rb : log_q[i].ra;
        r_oth = (exp_src[f] != 0) ? log_q[i].ra : log_q[i].rb;
        if (r_sel) begin
          rdn++;
          if (rdf < 0) rdf = k;
          rdl = k;
        end
        if (r_oth) rdo++;
      end
      check($sformatf("%s.f%0d.bad_octets", tag, f), nbad, 0);
      check($sformatf("%s.f%0d.gnt_cycles", tag, f), gn, 1);
      check($sformatf("%s.f%0d.busy_low", tag, f), blow, 0);
      check($sformatf("%s.f%0d.rd_count", tag, f), rdn, le);
      check($sformatf("%s.f%0d.rd_first", tag, f), rdf, 7);
      check($sformatf("%s.f%0d.rd_last", tag, f), rdl, 6 + le);
      check($sformatf("%s.f%0d.rd_other", tag, f), rdo, 0);
      prev_end = e;
      pos = e;
    end
    extra = 0;
    for (int i = pos; i < log_q.size(); i++) if (log_q[i].en || log_q[i].ga || log_q[i].gb) extra++;
    check($sformatf("%s.no_extra", tag), extra, 0);
    if (pos + gap < log_q.size())
      check($sformatf("%s.busy_tail", tag), {log_q[pos+gap-1].busy, log_q[pos+gap].busy}, 2'b10);
  endtask

  task automatic start_rec();
    log_q.delete();
    rec = 1'b1;
  endtask

  initial begin
    int n, m;
    bus.req_a = 1'b0;  bus.req_b = 1'b0;
    bus.len_a = '0;    bus.len_b = '0;
    bus.data_a = 8'h00; bus.data_b = 8'h00;
    bus4.req_a = 1'b0; bus4.req_b = 1'b0;
    bus4.len_a = '0;   bus4.len_b = '0;
    bus4.data_a = 8'h3C; bus4.data_b = 8'h00;

    repeat (3) @(posedge gtx_clk);
    #2;
    check("reset_outputs",
          {bus.TX_EN, bus.tx_octet, bus.gnt_a, bus.gnt_b, bus.rd_a, bus.rd_b, bus.busy}, '0);
    rst_n = 1'b1;
    @(posedge gtx_clk); #2;

    // tie right after reset: A first, then B after exactly 12 idle cycles
    start_rec();
    bus.len_a = 11'd2; bus.len_b = 11'd2;
    gnts_a = 0; gnts_b = 0; lim_a = 1; lim_b = 1;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    repeat (60) @(posedge gtx_clk); #2;
    rec = 1'b0;
    exp_src[0] = 0; exp_len[0] = 2;
    exp_src[1] = 1; exp_len[1] = 2;
    analyze("tie", 2, 1, 12);

    // single frame from A, len 4
    start_rec();
    bus.len_a = 11'd4; gnts_a = 0; lim_a = 1;
    bus.req_a = 1'b1;
    repeat (40) @(posedge gtx_clk); #2;
    rec = 1'b0;
    exp_src[0] = 0; exp_len[0] = 4;
    analyze("single", 1, 1, 12);

    // zero length from B
    start_rec();
    bus.len_b = 11'd0; gnts_b = 0; lim_b = 1;
    bus.req_b = 1'b1;
    repeat (40) @(posedge gtx_clk); #2;
    rec = 1'b0;
    exp_src[0] = 1; exp_len[0] = 0;
    analyze("zero_len", 1, 1, 12);

    // both held for four frames: A, B, A, B
    start_rec();
    bus.len_a = 11'd3; bus.len_b = 11'd3;
    gnts_a = 0; gnts_b = 0; lim_a = 2; lim_b = 2;
    bus.req_a = 1'b1; bus.req_b = 1'b1;
    repeat (110) @(posedge gtx_clk); #2;
    rec = 1'b0;
    for (int f = 0; f < 4; f++) begin
      exp_src[f] = f % 2;
      exp_len[f] = 3;
    end
    analyze("continuous", 4, 1, 12);

    // reset during payload byte 3 of a len-10 frame
    bus.len_a = 11'd10; gnts_a = 0; lim_a = 1;
    bus.req_a = 1'b1;
    n = 0;
    while (n < 5) begin
      @(negedge gtx_clk);
      if (bus.gnt_a) break;
      n++;
    end
    check("rst_mid.gnt_seen", 32'(n < 5), 1);
    repeat (10) @(posedge gtx_clk); #2;
    check("rst_mid.byte3", bus.tx_octet, 8'hA3);
    rst_n = 1'b0;
    bus.len_b = 11'd2; gnts_b = 0; lim_b = 1;
    bus.req_b = 1'b1;
    @(posedge gtx_clk); #2;
    check("rst_mid.outputs",
          {bus.TX_EN, bus.tx_octet, bus.gnt_a, bus.gnt_b, bus.rd_a, bus.rd_b, bus.busy}, '0);
    rst_n = 1'b1;
    @(posedge gtx_clk); #2;
    check("rst_mid.regrant_b", {bus.gnt_b, bus.TX_EN, bus.tx_octet, bus.busy}, {1'b1, 1'b1, 8'h55, 1'b1});
    repeat (30) @(posedge gtx_clk); #2;

    // max length with a 4-cycle gap on the second instance
    bus4.len_a = 11'd2047;
    bus4.req_a = 1'b1;
    n = 0;
    while (!bus4.TX_EN && n < 5) begin
      @(posedge gtx_clk); #2;
      n++;
    end
    check("maxlen.start", bus4.gnt_a, 1'b1);
    n = 0;
    while (bus4.TX_EN && n < 3000) begin
      @(posedge gtx_clk); #2;
      n++;
    end
    check("maxlen.en_len", n, 2055);
    m = 0;
    while (!bus4.TX_EN && m < 50) begin
      @(posedge gtx_clk); #2;
      m++;
    end
    check("maxlen.gap", m, 4);
    check("maxlen.regrant", {bus4.gnt_a, bus4.tx_octet}, {1'b1, 8'h55});
    bus4.req_a = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
